aes_inv_round_unit: RTL and testbench
=====================================

// Module: aes_inv_round_unit
// PURPOSE
// - One registered AES inverse-cipher round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
// - Also performs the initial key whitening (AddRoundKey only).
// - Driven once per round by the decryption sequencer, which supplies the state and the round key.
// - The unit holds no key schedule and no round counter.
// PARAMETERS
// - none. The datapath is fixed at 128 bits; key length is the sequencer's concern.
// PORTS
// clks        in   1    rising-edge clock (the single clock)
// reset       in   1    asynchronous, active-low reset
// in_valid    in   1    state_in/round_key/mode are captured this cycle
// mode        in   2    00 = ARK only; 01 = middle round; 10 = final round; 11 = same as 01
// state_in    in   128  [0:127], byte k = bits 8k..8k+7, state[r][c] = byte 4c+r
// round_key   in   128  same byte order as state_in
// state_out   out  128  registered round result
// out_valid   out  1    state_out holds a new result
// BEHAVIOUR
// - Reset (reset=0, asynchronous): state_out=0 and out_valid=0 immediately. Both are held while reset is low.
// - Latency is 1 cycle. At a clock edge with in_valid=1, the result of the captured inputs is loaded into state_out, and out_valid=1 in the next cycle.
// - With in_valid=0: out_valid=0 and state_out holds its last value. There is no backpressure; a new input is accepted every cycle.
// - mode 00: out = state_in ^ round_key.
// - mode 10: out = InvSubBytes(InvShiftRows(state_in)) ^ round_key.
// - mode 01/11: out = InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ round_key).
// - InvShiftRows: row r is rotated right by r positions, i.e. out[r][c] = in[r][(c-r) mod 4].
// - InvSubBytes: each byte is replaced by the FIPS-197 inverse S-box value (0x00->0x52, 0x63->0x00, 0x7c->0x01).
// - InvMixColumns: in GF(2^8) with poly 0x11b, each column is multiplied by {0e 0b 0d 09} circulant.
//   - b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3, rotated for b1..b3.
//   - All arithmetic is 8-bit XOR/xtime; there are no carries beyond 8 bits.
// - The datapath between input and register is purely combinational. The only state is state_out/out_valid.
// - Reset asserted mid-operation: any pending result is discarded and out_valid=0 on the following edge after release until a new in_valid.
// - X-free requirement: a mode value of 11 must never propagate X.
// STRUCTURE
// - aes_pkg holds:
//   - the 256-entry inverse S-box constant;
//   - the functions xtime, gmul09/0b/0d/0e and inv_mix_column(32b);
//   - the mode localparams MODE_ARK/MODE_MID/MODE_FINAL.
// - One sub-module, aes_inv_sub_bytes: 128-bit combinational, 16 instances of the table lookup.
// - InvShiftRows and AddRoundKey are plain wiring/XOR in the top.
// TESTING
// - Reset: drop reset asynchronously mid-cycle -> state_out=0 and out_valid=0 without waiting for a clock edge.
// - ARK (mode 00):
//   - state_in = 69c4e0d86a7b0430d8cdb78070b4c55a
//   - round_key = 13111d7fe3944a17f307a78b4d2b30c5
//   - expect 7ad5fda789ef4e272bca100b3d9ff59f after 1 cycle, out_valid=1.
// - Middle round (mode 01):
//   - state_in = 7ad5fda789ef4e272bca100b3d9ff59f
//   - round_key = 549932d1f08557681093ed9cbe2c974e
//   - expect 54d990a16ba09ab596bbf40ea111702f.
// - Final round (mode 10):
//   - state_in = 6353e08c0960e104cd70b751bacad0e7
//   - round_key = 000102030405060708090a0b0c0d0e0f
//   - expect 00112233445566778899aabbccddeeff.
// - S-box corners (mode 10, key = 0):
//   - state_in all 63 -> output all 00.
//   - state_in all 00 -> output all 52.
// - Back-to-back: the three vectors above on consecutive cycles -> each result one cycle later, out_valid high for three cycles, then 0.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and GF(2^8) helpers for the AES inverse-round datapath.
//   - MODE_* : round-type encodings driven on the unit's mode input
//   - INV_SBOX : FIPS-197 inverse S-box (256 entries)
//   - xtime / gmul09 / gmul0b / gmul0d / gmul0e : constant multipliers, poly 0x11b
//   - inv_mix_column : one 32-bit column through the {0e 0b 0d 09} circulant.
//     The column's row 0 byte is the most significant byte.
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam logic [1:0] MODE_ARK   = 2'b00;
   localparam logic [1:0] MODE_MID   = 2'b01;
   localparam logic [1:0] MODE_FINAL = 2'b10;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Multiply by {02}: shift left and fold bit 8 back with the 0x1b remainder.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul09(input logic [7:0] b);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(b)));
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = xtime(b);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] b);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = xtime(xtime(b));
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] b);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      {a0, a1, a2, a3} = col;
      return {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
              gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
              gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
              gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
   endfunction

endpackage

// File: rtl/aes_inv_sub_bytes.sv
// -----------------------------------------------------------------------------
// aes_inv_sub_bytes
// Combinational InvSubBytes over a 128-bit state: every byte goes through its
// own inverse S-box lookup. Byte position is preserved.
//   i_state : 128-bit state before substitution
//   o_state : 128-bit state after substitution
// -----------------------------------------------------------------------------
module aes_inv_sub_bytes
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);

   for (genvar g = 0; g < 16; g++) begin : g_byte
      assign o_state[8*g +: 8] = INV_SBOX[i_state[8*g +: 8]];
   end

endmodule

// File: rtl/aes_inv_round_unit.sv
// -----------------------------------------------------------------------------
// aes_inv_round_unit
// One registered AES inverse-cipher round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns,
// or plain AddRoundKey for the initial key whitening. No key schedule and no
// round counter live here; the decryption sequencer drives one round per call.
// Ports:
//   clks      : rising-edge clock
//   reset     : asynchronous, active-low reset
//   in_valid  : state_in / round_key / mode are captured on this edge
//   mode      : 00 ARK only, 01 middle round, 10 final round, 11 same as 01
//   state_in  : 128-bit state, byte k at bits [127-8k -: 8] (byte 0 is the
//               most significant byte); state[r][c] = byte 4c+r
//   round_key : 128-bit round key, same byte order as state_in
//   state_out : registered round result (held while in_valid is low)
//   out_valid : state_out holds a result captured on the previous edge
// -----------------------------------------------------------------------------
module aes_inv_round_unit
   import aes_pkg::*;
(
   input  logic         clks,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [1:0]   mode,
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   output logic [127:0] state_out,
   output logic         out_valid
);

   logic [127:0] w_shifted;
   logic [127:0] w_subbed;
   logic [127:0] w_sub_ark;
   logic [127:0] w_mixed;
   logic [127:0] w_result;
   logic [127:0] r_state_p1;
   logic         r_vld_p1;

   // InvShiftRows: out[r][c] = in[r][(c-r) mod 4], pure wiring.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign w_shifted[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
   end

   aes_inv_sub_bytes u_inv_sub_bytes (
      .i_state (w_shifted),
      .o_state (w_subbed)
   );

   assign w_sub_ark = w_subbed ^ round_key;

   // Each 32-bit column (row 0 in the top byte) through InvMixColumns.
   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign w_mixed[127-32*c -: 32] = inv_mix_column(w_sub_ark[127-32*c -: 32]);
   end

   // Mode 11 aliases the middle round; every 2-bit code selects a defined path.
   always_comb begin
      w_result = w_mixed;
      case (mode)
         MODE_ARK:   w_result = state_in ^ round_key;
         MODE_FINAL: w_result = w_sub_ark;
         MODE_MID:   w_result = w_mixed;
         default:    w_result = w_mixed;
      endcase
   end

   // ---- stage p1: result register ----
   always_ff @(posedge clks or negedge reset) begin
      if (!reset) begin
         r_state_p1 <= '0;
         r_vld_p1   <= 1'b0;
      end else begin
         r_vld_p1 <= in_valid;
         if (in_valid) begin
            r_state_p1 <= w_result;
         end
      end
   end

   assign state_out = r_state_p1;
   assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_aes_inv_round_unit.sv
module tb_aes_inv_round_unit;

   logic         clks = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [127:0] state_in = '0;
   logic [127:0] round_key = '0;
   logic [127:0] state_out;
   logic         out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   ref_isbox [256];
   logic [127:0] exp_state = '0;
   logic         exp_vld = 1'b0;

   localparam logic [127:0] V_ARK_S = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] V_ARK_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] V_ARK_E = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
   localparam logic [127:0] V_MID_S = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
   localparam logic [127:0] V_MID_K = 128'h549932d1f08557681093ed9cbe2c974e;
   localparam logic [127:0] V_MID_E = 128'h54d990a16ba09ab596bbf40ea111702f;
   localparam logic [127:0] V_FIN_S = 128'h6353e08c0960e104cd70b751bacad0e7;
   localparam logic [127:0] V_FIN_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] V_FIN_E = 128'h00112233445566778899aabbccddeeff;

   aes_inv_round_unit dut (
      .clks      (clks),
      .reset     (reset),
      .in_valid  (in_valid),
      .mode      (mode),
      .state_in  (state_in),
      .round_key (round_key),
      .state_out (state_out),
      .out_valid (out_valid)
   );

   always #5 clks = ~clks;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Schoolbook GF(2^8) multiply followed by long division by 0x11b.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      int p;
      int aa;
      p  = 0;
      aa = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa << 1;
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (32'h11b << (i - 8));
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // Derive the inverse S-box from the forward S-box definition:
   // S(x) = affine(x^-1), then invert the permutation.
   task automatic build_isbox();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         ref_isbox[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] ref_round(input logic [1:0] m, input logic [127:0] s,
                                              input logic [127:0] k);
      logic [7:0]   a [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] res;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            a[r][c] = s[127 - 8*(4*c + r) -: 8];
      if (m == 2'b00) return s ^ k;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = ref_isbox[a[r][(c - r + 4) % 4]] ^ k[127 - 8*(4*c + r) -: 8];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (m == 2'b10)
               res[127 - 8*(4*c + r) -: 8] = t[r][c];
            else
               res[127 - 8*(4*c + r) -: 8] = gf_mul(8'h0e, t[r][c]) ^
                                              gf_mul(8'h0b, t[(r + 1) % 4][c]) ^
                                              gf_mul(8'h0d, t[(r + 2) % 4][c]) ^
                                              gf_mul(8'h09, t[(r + 3) % 4][c]);
         end
      return res;
   endfunction

   // Called just after a rising edge: drive inputs, advance one edge, check.
   task automatic cycle(input logic v, input logic [1:0] m, input logic [127:0] s,
                        input logic [127:0] k, input string tag,
                        input bit use_kat, input logic [127:0] kat);
      in_valid  = v;
      mode      = m;
      state_in  = s;
      round_key = k;
      @(posedge clks);
      #1;
      if (v) exp_state = ref_round(m, s, k);
      exp_vld = v;
      check_val({tag, "_vld"}, {127'b0, out_valid}, {127'b0, exp_vld});
      check_val({tag, "_out"}, state_out, exp_state);
      if (use_kat) check_val({tag, "_kat"}, state_out, kat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      build_isbox();

      // Asynchronous reset, checked between clock edges.
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_val("rst_async_vld", {127'b0, out_valid}, 128'd0);
      check_val("rst_async_out", state_out, 128'd0);
      @(posedge clks);
      #1;
      check_val("rst_hold_vld", {127'b0, out_valid}, 128'd0);
      check_val("rst_hold_out", state_out, 128'd0);
      #2 reset = 1'b1;
      cycle(1'b0, 2'b00, '0, '0, "post_rst", 1'b0, '0);

      // Known-answer vectors and S-box corners.
      cycle(1'b1, 2'b00, V_ARK_S, V_ARK_K, "ark", 1'b1, V_ARK_E);
      cycle(1'b1, 2'b01, V_MID_S, V_MID_K, "mid", 1'b1, V_MID_E);
      cycle(1'b1, 2'b10, V_FIN_S, V_FIN_K, "fin", 1'b1, V_FIN_E);
      cycle(1'b1, 2'b10, {16{8'h63}}, '0, "sbox63", 1'b1, '0);
      cycle(1'b1, 2'b10, '0, '0, "sbox00", 1'b1, {16{8'h52}});
      cycle(1'b1, 2'b11, V_MID_S, V_MID_K, "mode11", 1'b1, V_MID_E);
      cycle(1'b0, 2'b00, V_ARK_S, V_ARK_K, "idle_hold", 1'b1, V_MID_E);

      // Back-to-back, then idle.
      cycle(1'b1, 2'b00, V_ARK_S, V_ARK_K, "b2b_ark", 1'b1, V_ARK_E);
      cycle(1'b1, 2'b01, V_MID_S, V_MID_K, "b2b_mid", 1'b1, V_MID_E);
      cycle(1'b1, 2'b10, V_FIN_S, V_FIN_K, "b2b_fin", 1'b1, V_FIN_E);
      cycle(1'b0, 2'b01, V_MID_S, V_MID_K, "b2b_idle", 1'b1, V_FIN_E);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               {$urandom(), $urandom(), $urandom(), $urandom()},
               {$urandom(), $urandom(), $urandom(), $urandom()},
               "rand", 1'b0, '0);
      end

      // Reset dropped mid-cycle with a transaction pending.
      cycle(1'b1, 2'b01, V_MID_S, V_MID_K, "pre_rst", 1'b1, V_MID_E);
      in_valid  = 1'b1;
      mode      = 2'b00;
      state_in  = V_ARK_S;
      round_key = V_ARK_K;
      #3 reset = 1'b0;
      #1;
      check_val("rst_mid_vld", {127'b0, out_valid}, 128'd0);
      check_val("rst_mid_out", state_out, 128'd0);
      @(posedge clks);
      #1;
      check_val("rst_mid_hold_vld", {127'b0, out_valid}, 128'd0);
      check_val("rst_mid_hold_out", state_out, 128'd0);
      in_valid = 1'b0;
      #3 reset = 1'b1;
      exp_state = '0;
      exp_vld   = 1'b0;
      cycle(1'b0, 2'b00, V_ARK_S, V_ARK_K, "rel_idle", 1'b0, '0);
      cycle(1'b1, 2'b10, V_FIN_S, V_FIN_K, "rel_fin", 1'b1, V_FIN_E);
      cycle(1'b0, 2'b10, '0, '0, "rel_end", 1'b0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
